// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch queue: owns the sequential fetch PC, issues in-order requests under a
// credit limit, buffers returned words with their PCs, and flushes everything on a redirect.
`timescale 1ns/1ps
module ifu_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] fetch_pc
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    // Outstanding can exceed DEPTH while stale returns are still being drained.
    localparam int OW = AW + 4;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   tag_pc     [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding, drop, live;
    logic          grant, ret_live, push, pop;

    always_comb begin
        live      = outstanding - drop;
        imem_req  = !reset && !redirect_valid && ((OW'(count) + live) < DEPTH_C);
        imem_addr = fetch_pc;
        grant     = imem_req && imem_gnt;
        ret_live  = imem_rvalid && (drop == '0);
        push      = ret_live && !redirect_valid && !reset;
        out_valid = (count != '0);
        pop       = out_valid && out_ready;
        out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
        out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= PC_RESET;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_valid) begin
            // A return landing in the redirect cycle is stale, so it is excluded from drop.
            fetch_pc    <= redirect_pc;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            outstanding <= outstanding - OW'(imem_rvalid);
            drop        <= outstanding - OW'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
                tag_wr   <= tag_wr + AW'(1);
            end
            outstanding <= outstanding + OW'(grant) - OW'(imem_rvalid);
            if (imem_rvalid && (drop != '0))
                drop <= drop - OW'(1);
            if (ret_live) begin
                wr_ptr <= wr_ptr + AW'(1);
                tag_rd <= tag_rd + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(ret_live) - CW'(pop);
        end
    end

    // Payload storage carries no reset; validity is tracked by count and the tag pointers.
    always_ff @(posedge clk) begin
        if (grant)
            tag_pc[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end
endmodule
